// File: rtl/fpu_wb_cmdq_if.sv
// fpu_wb_cmdq_if: Wishbone slave bus plus FPU request/response handshake for fpu_wb_cmdq.
interface fpu_wb_cmdq_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int FLAG_W = 5
);
   logic              wbs_stb_i;
   logic              wbs_cyc_i;
   logic              wbs_we_i;
   logic [3:0]        wbs_sel_i;
   logic [31:0]       wbs_adr_i;
   logic [31:0]       wbs_dat_i;
   logic              wbs_ack_o;
   logic [31:0]       wbs_dat_o;
   logic              fpu_req_valid_o;
   logic              fpu_req_ready_i;
   logic [OP_W-1:0]   fpu_op_o;
   logic [DATA_W-1:0] fpu_opa_o;
   logic [DATA_W-1:0] fpu_opb_o;
   logic              fpu_rsp_valid_i;
   logic [DATA_W-1:0] fpu_result_i;
   logic [FLAG_W-1:0] fpu_flags_i;
   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  fpu_req_ready_i, fpu_rsp_valid_i, fpu_result_i, fpu_flags_i,
      output wbs_ack_o, wbs_dat_o, fpu_req_valid_o, fpu_op_o, fpu_opa_o, fpu_opb_o
   );
   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output fpu_req_ready_i, fpu_rsp_valid_i, fpu_result_i, fpu_flags_i,
      input  wbs_ack_o, wbs_dat_o, fpu_req_valid_o, fpu_op_o, fpu_opa_o, fpu_opb_o
   );
endinterface

// File: rtl/fpu_wb_cmdq.sv
// fpu_wb_cmdq: Wishbone command/result queue feeding a single-issue FPU core.
module fpu_wb_cmdq #(
   parameter int          DATA_W   = 32,
   parameter int          OP_W     = 4,
   parameter int          FLAG_W   = 5,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_ni,
   fpu_wb_cmdq_if.slave bus,
   output logic         irq_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t            state_q;
   logic [31:0]       opa_q, opa_d, opb_q, opb_d, dat_q, dat_d, rdata, status;
   logic              ack_q, irq_q, irq_en_q, irq_en_d, ovf_q, ovf_d, unf_q, unf_d, valid_q;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] iss_a_q, iss_b_q;
   logic [OP_W-1:0]   cmd_op_q [DEPTH];
   logic [DATA_W-1:0] cmd_a_q [DEPTH];
   logic [DATA_W-1:0] cmd_b_q [DEPTH];
   logic [DATA_W-1:0] res_q [DEPTH];
   logic [FLAG_W-1:0] flg_q [DEPTH];
   logic [AW-1:0]     cwp_q, crp_q, rwp_q, rrp_q;
   logic [CW-1:0]     ccnt_q, ccnt_d, rcnt_q, rcnt_d;
   logic [7:0]        off;
   logic              acc, wr, rd, cmd_wr, cmd_full, cmd_push, cmd_pop;
   logic              rsp_rd, rsp_empty, rsp_push, rsp_pop, st_wr;

   function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] dat,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
      return r;
   endfunction

   // ack_q blocks a second access while the master still holds its strobe
   assign off       = bus.wbs_adr_i[7:0];
   assign acc       = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
   assign wr        = acc & bus.wbs_we_i;
   assign rd        = acc & ~bus.wbs_we_i;
   assign cmd_full  = ccnt_q == FULL;
   assign cmd_pop   = valid_q & bus.fpu_req_ready_i;
   assign cmd_wr    = wr & (off == 8'h08);
   assign cmd_push  = cmd_wr & (~cmd_full | cmd_pop);
   assign rsp_empty = rcnt_q == '0;
   assign rsp_rd    = rd & (off == 8'h0C);
   assign rsp_pop   = rsp_rd & ~rsp_empty;
   assign rsp_push  = (state_q == WAIT) & bus.fpu_rsp_valid_i;
   assign st_wr     = wr & (off == 8'h14) & bus.wbs_sel_i[2];

   always_comb begin
      opa_d    = (wr && off == 8'h00) ? lanes(opa_q, bus.wbs_dat_i, bus.wbs_sel_i) : opa_q;
      opb_d    = (wr && off == 8'h04) ? lanes(opb_q, bus.wbs_dat_i, bus.wbs_sel_i) : opb_q;
      irq_en_d = (wr && off == 8'h18 && bus.wbs_sel_i[0]) ? bus.wbs_dat_i[0] : irq_en_q;
      ovf_d    = (cmd_wr & cmd_full & ~cmd_pop) | (ovf_q & ~(st_wr & bus.wbs_dat_i[17]));
      unf_d    = (rsp_rd & rsp_empty) | (unf_q & ~(st_wr & bus.wbs_dat_i[18]));
      ccnt_d   = ccnt_q + CW'(cmd_push) - CW'(cmd_pop);
      rcnt_d   = rcnt_q + CW'(rsp_push) - CW'(rsp_pop);
      status   = {13'b0, unf_q, ovf_q, state_q != IDLE, 4'b0, 4'(rcnt_q), 4'b0, 4'(ccnt_q)};
      rdata    = (off == 8'h00) ? opa_q :
                 (off == 8'h04) ? opb_q :
                 (off == 8'h0C) ? (rsp_empty ? 32'b0 : 32'(res_q[rrp_q])) :
                 (off == 8'h10) ? (rsp_empty ? 32'b0 : 32'(flg_q[rrp_q])) :
                 (off == 8'h14) ? status :
                 (off == 8'h18) ? {31'b0, irq_en_q} : 32'b0;
      dat_d    = rd ? rdata : 32'b0;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         ccnt_q   <= '0;
         rcnt_q   <= '0;
         cwp_q    <= '0;
         crp_q    <= '0;
         rwp_q    <= '0;
         rrp_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            cmd_op_q[i] <= '0;
            cmd_a_q[i]  <= '0;
            cmd_b_q[i]  <= '0;
            res_q[i]    <= '0;
            flg_q[i]    <= '0;
         end
      end else begin
         ack_q    <= acc;
         dat_q    <= dat_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_en_q & ~rsp_empty;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         ccnt_q   <= ccnt_d;
         rcnt_q   <= rcnt_d;
         if (cmd_push) begin
            cmd_op_q[cwp_q] <= bus.wbs_dat_i[OP_W-1:0];
            cmd_a_q[cwp_q]  <= DATA_W'(opa_q);
            cmd_b_q[cwp_q]  <= DATA_W'(opb_q);
            cwp_q           <= cwp_q + AW'(1);
         end
         if (cmd_pop) crp_q <= crp_q + AW'(1);
         if (rsp_push) begin
            res_q[rwp_q] <= bus.fpu_result_i;
            flg_q[rwp_q] <= bus.fpu_flags_i;
            rwp_q        <= rwp_q + AW'(1);
         end
         if (rsp_pop) rrp_q <= rrp_q + AW'(1);
      end
   end

   // Issue only with a free result slot, so a returning result always has room
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         op_q    <= '0;
         iss_a_q <= '0;
         iss_b_q <= '0;
      end else begin
         case (state_q)
            IDLE:
               if (ccnt_q != '0 && rcnt_q != FULL) begin
                  state_q <= ISSUE;
                  valid_q <= 1'b1;
                  op_q    <= cmd_op_q[crp_q];
                  iss_a_q <= cmd_a_q[crp_q];
                  iss_b_q <= cmd_b_q[crp_q];
               end
            ISSUE:
               if (bus.fpu_req_ready_i) begin
                  state_q <= WAIT;
                  valid_q <= 1'b0;
               end
            WAIT:
               if (bus.fpu_rsp_valid_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.wbs_ack_o       = ack_q;
   assign bus.wbs_dat_o       = dat_q;
   assign bus.fpu_req_valid_o = valid_q;
   assign bus.fpu_op_o        = op_q;
   assign bus.fpu_opa_o       = iss_a_q;
   assign bus.fpu_opb_o       = iss_b_q;
   assign irq_o               = irq_q;
endmodule
